usb_in_ep_arbiter: RTL and testbench
====================================

Name: usb_in_ep_arbiter

Overview:
Weighted round-robin scheduler that shares the single FT601 IN write channel between the EP2 (MSC: CSW + sector data) and EP3 (Raw: flux + diagnostics) response streams. It grants one endpoint at a time for a bounded burst and tags each word with its endpoint number. Bursts end at a packet boundary, at the burst limit or on an idle timeout, so a long flux capture cannot starve MSC traffic. Sits between the composite interface mux outputs and the FT601 interface transmit path.

Parameters:
BURST_WORDS, 256, max 32-bit words per grant (1..4096)
MSC_WEIGHT, 1, bursts granted to EP2 per round (1..15)
RAW_WEIGHT, 3, bursts granted to EP3 per round (1..15)
IDLE_TIMEOUT, 16, consecutive cycles of source valid low that end a burst early (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
arb_enable  in  1  1 = new grants allowed
ep_mask  in  2  bit0 = block EP2, bit1 = block EP3 (sampled only in IDLE)
ep2_data  in  32  MSC stream data
ep2_valid  in  1  MSC word valid
ep2_last  in  1  MSC packet end, qualified by valid
ep2_ready  out  1  MSC word accepted
ep3_data  in  32  Raw stream data
ep3_valid  in  1  Raw word valid
ep3_last  in  1  Raw packet end, qualified by valid
ep3_ready  out  1  Raw word accepted
tx_data  out  32  to FT601 write path
tx_valid  out  1  tx word valid
tx_ready  in  1  FT601 accepts word
tx_ep  out  2  endpoint of current word: 2 or 3; 0 when idle
tx_last  out  1  final word of burst
tx_flush  out  1  one-cycle pulse: commit short burst ended by timeout
grant_ep  out  2  0 = none, 2 = EP2, 3 = EP3
msc_burst_count  out  16  completed EP2 bursts, wraps
raw_burst_count  out  16  completed EP3 bursts, wraps
arb_state  out  2  current FSM state

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; credits load MSC_WEIGHT/RAW_WEIGHT; last_served = EP3, so EP2 wins the first tie.
- States: IDLE(0), GRANT_MSC(1), GRANT_RAW(2).
- Eligibility: an endpoint is eligible if arb_enable is 1, its mask bit is 0, valid is 1 and its credit is > 0.
- IDLE priority: prefer the eligible endpoint not in last_served; otherwise last_served if eligible.
- No credit: if a requester is valid and unmasked but no endpoint is eligible only for lack of credit, reload both credits that cycle and stay IDLE. The reload costs 1 bubble.
- Grant: taken at the IDLE clock edge. Latency is 1 cycle from valid to first transfer.
- During a grant the datapath is combinational pass-through:
  - tx_data = src data; tx_valid = src valid; src ready = tx_ready; tx_ep = 2 or 3.
  - The non-granted ready is 0.
- Transfer: a word transfers when tx_valid and tx_ready are both 1. word_cnt (width clog2(BURST_WORDS+1)) increments per transfer.
- tx_last = tx_valid & (src last | word_cnt == BURST_WORDS-1). The burst ends on the transfer of a tx_last word.
- Idle timer: increments on cycles with src valid low, clears on src valid high. It does not count while tx_ready is low with valid high, so backpressure never times out.
- Timeout: when the timer reaches IDLE_TIMEOUT, the burst ends that cycle. tx_flush pulses only if word_cnt > 0. A zero-word timeout still consumes credit.
- Burst end: decrement the granted credit, set last_served, increment that burst counter (wrap 0xFFFF to 0), clear word_cnt and the timer, return to IDLE.
- The grant never switches mid-burst. arb_enable low and mask changes take effect only at the next IDLE.
- Simultaneous src last and count limit: one burst end, tx_last asserted once.
- BURST_WORDS = 1: every word carries tx_last.

Test Plan:
- EP2 only, 600 continuous words, last on word 600, tx_ready = 1:
  - bursts of 256, 256, 88, with tx_last on words 256, 512 and 600;
  - msc_burst_count = 3;
  - one reload bubble before burst 2.
- EP2 and EP3 both continuously valid, weights 1:3 → grant order EP2, EP3, EP3, EP3, EP2, … with a reload bubble between rounds.
- EP3 sends 10 words then valid low → tx_flush pulses on the 16th idle cycle, tx_last never asserted, state back to IDLE, raw_burst_count = 1.
- EP3 granted, tx_ready low for 100 cycles with valid high → no timeout, no flush; word_cnt unchanged until ready returns.
- ep_mask = 01 with both valid → only EP3 granted. Set the mask to 10 mid-burst → the current EP3 burst completes, next grant goes to EP2.
- Assert rst at word 40 of an EP2 burst → tx_valid, ep2_ready and grant_ep go to 0 asynchronously. After release with both valid, EP2 is granted first and counters read 0.

Source files
------------

// File: rtl/usb_in_ep_arbiter.sv
// usb_in_ep_arbiter
// Weighted round-robin scheduler sharing the FT601 IN write channel between
// the EP2 (MSC) and EP3 (Raw) response streams. One endpoint owns the channel
// per burst; a burst ends on a packet boundary, the burst word limit, or an
// idle timeout. During a grant the data path is a combinational pass-through.
module usb_in_ep_arbiter #(
  parameter int BURST_WORDS  = 256,
  parameter int MSC_WEIGHT   = 1,
  parameter int RAW_WEIGHT   = 3,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arb_enable,
  input  logic [1:0]  ep_mask,
  input  logic [31:0] ep2_data,
  input  logic        ep2_valid,
  input  logic        ep2_last,
  output logic        ep2_ready,
  input  logic [31:0] ep3_data,
  input  logic        ep3_valid,
  input  logic        ep3_last,
  output logic        ep3_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [1:0]  tx_ep,
  output logic        tx_last,
  output logic        tx_flush,
  output logic [1:0]  grant_ep,
  output logic [15:0] msc_burst_count,
  output logic [15:0] raw_burst_count,
  output logic [1:0]  arb_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_MSC = 2'd1,
    GRANT_RAW = 2'd2
  } state_t;

  localparam int             WCW         = $clog2(BURST_WORDS + 1);
  localparam logic [WCW-1:0] WORD_LIMIT  = WCW'(BURST_WORDS - 1);
  localparam logic [WCW-1:0] WORD_ONE    = WCW'(1);
  localparam logic [7:0]     TIMEOUT_M1  = 8'(IDLE_TIMEOUT - 1);
  localparam logic [3:0]     MSC_INIT    = 4'(MSC_WEIGHT);
  localparam logic [3:0]     RAW_INIT    = 4'(RAW_WEIGHT);

  state_t         state_r;
  logic [3:0]     msc_credit_r;
  logic [3:0]     raw_credit_r;
  logic           last_raw_r;     // 1 = EP3 was the last endpoint served
  logic [WCW-1:0] word_cnt_r;
  logic [7:0]     idle_cnt_r;
  logic [15:0]    msc_count_r;
  logic [15:0]    raw_count_r;

  logic [31:0]    src_data_s;
  logic           src_valid_s;
  logic           src_last_s;
  logic           in_grant_s;
  logic [1:0]     grant_ep_s;
  logic           xfer_s;
  logic           tx_last_s;
  logic           timeout_s;
  logic           burst_end_s;
  logic           req_msc_s;
  logic           req_raw_s;
  logic           elig_msc_s;
  logic           elig_raw_s;
  logic           pick_msc_s;
  logic           pick_raw_s;
  logic           reload_s;

  // Route the granted source onto the transmit side; nothing is routed in IDLE.
  always_comb begin
    src_data_s  = 32'd0;
    src_valid_s = 1'b0;
    src_last_s  = 1'b0;
    in_grant_s  = 1'b0;
    grant_ep_s  = 2'd0;
    case (state_r)
      GRANT_MSC: begin
        src_data_s  = ep2_data;
        src_valid_s = ep2_valid;
        src_last_s  = ep2_last;
        in_grant_s  = 1'b1;
        grant_ep_s  = 2'd2;
      end
      GRANT_RAW: begin
        src_data_s  = ep3_data;
        src_valid_s = ep3_valid;
        src_last_s  = ep3_last;
        in_grant_s  = 1'b1;
        grant_ep_s  = 2'd3;
      end
      default: begin
        in_grant_s  = 1'b0;
      end
    endcase
  end

  assign xfer_s      = src_valid_s & tx_ready;
  assign tx_last_s   = src_valid_s & (src_last_s | (word_cnt_r == WORD_LIMIT));
  // Timer holds IDLE_TIMEOUT-1 on the IDLE_TIMEOUT-th consecutive idle cycle.
  assign timeout_s   = in_grant_s & ~src_valid_s & (idle_cnt_r == TIMEOUT_M1);
  assign burst_end_s = (xfer_s & tx_last_s) | timeout_s;

  assign req_msc_s   = arb_enable & ~ep_mask[0] & ep2_valid;
  assign req_raw_s   = arb_enable & ~ep_mask[1] & ep3_valid;
  assign elig_msc_s  = req_msc_s & (msc_credit_r != 4'd0);
  assign elig_raw_s  = req_raw_s & (raw_credit_r != 4'd0);

  // Choose the next endpoint in IDLE, favouring the one not served last; reload credits when only credit blocks a requester.
  always_comb begin
    pick_msc_s = 1'b0;
    pick_raw_s = 1'b0;
    if (last_raw_r) begin
      if (elig_msc_s) begin
        pick_msc_s = 1'b1;
      end else if (elig_raw_s) begin
        pick_raw_s = 1'b1;
      end else begin
        pick_msc_s = 1'b0;
      end
    end else begin
      if (elig_raw_s) begin
        pick_raw_s = 1'b1;
      end else if (elig_msc_s) begin
        pick_msc_s = 1'b1;
      end else begin
        pick_raw_s = 1'b0;
      end
    end
    if (!pick_msc_s && !pick_raw_s && (req_msc_s || req_raw_s)) begin
      reload_s = 1'b1;
    end else begin
      reload_s = 1'b0;
    end
  end

  // Arbiter FSM: grant, burst accounting, idle timer and credit bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      msc_credit_r <= MSC_INIT;
      raw_credit_r <= RAW_INIT;
      last_raw_r   <= 1'b1;
      word_cnt_r   <= '0;
      idle_cnt_r   <= 8'd0;
      msc_count_r  <= 16'd0;
      raw_count_r  <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          word_cnt_r <= '0;
          idle_cnt_r <= 8'd0;
          if (pick_msc_s) begin
            state_r <= GRANT_MSC;
          end else if (pick_raw_s) begin
            state_r <= GRANT_RAW;
          end else if (reload_s) begin
            msc_credit_r <= MSC_INIT;
            raw_credit_r <= RAW_INIT;
          end
        end
        GRANT_MSC, GRANT_RAW: begin
          if (burst_end_s) begin
            word_cnt_r <= '0;
            idle_cnt_r <= 8'd0;
            state_r    <= IDLE;
            if (state_r == GRANT_MSC) begin
              msc_credit_r <= msc_credit_r - 4'd1;
              last_raw_r   <= 1'b0;
              msc_count_r  <= msc_count_r + 16'd1;
            end else begin
              raw_credit_r <= raw_credit_r - 4'd1;
              last_raw_r   <= 1'b1;
              raw_count_r  <= raw_count_r + 16'd1;
            end
          end else begin
            if (xfer_s) begin
              word_cnt_r <= word_cnt_r + WORD_ONE;
            end
            // A valid word (even one held by backpressure) keeps the timer at zero.
            if (src_valid_s) begin
              idle_cnt_r <= 8'd0;
            end else begin
              idle_cnt_r <= idle_cnt_r + 8'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tx_data         = src_data_s;
  assign tx_valid        = src_valid_s;
  assign tx_ep           = grant_ep_s;
  assign tx_last         = tx_last_s;
  assign tx_flush        = timeout_s & (word_cnt_r != '0);
  assign grant_ep        = grant_ep_s;
  assign ep2_ready       = (state_r == GRANT_MSC) & tx_ready;
  assign ep3_ready       = (state_r == GRANT_RAW) & tx_ready;
  assign msc_burst_count = msc_count_r;
  assign raw_burst_count = raw_count_r;
  assign arb_state       = state_r;

endmodule

// File: tb/tb_usb_in_ep_arbiter.sv
// tb_usb_in_ep_arbiter
// Directed stimulus with a transfer scoreboard: each test loads source queues
// and pushes the hand-derived expected transfer sequence; an independent
// monitor pops and compares every word the arbiter hands to the FT601 side.
module tb_usb_in_ep_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        arb_enable;
  logic [1:0]  ep_mask;
  logic [31:0] ep2_data;
  logic        ep2_valid;
  logic        ep2_last;
  logic        ep2_ready;
  logic [31:0] ep3_data;
  logic        ep3_valid;
  logic        ep3_last;
  logic        ep3_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  tx_ep;
  logic        tx_last;
  logic        tx_flush;
  logic [1:0]  grant_ep;
  logic [15:0] msc_burst_count;
  logic [15:0] raw_burst_count;
  logic [1:0]  arb_state;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  ep;
    logic        last;
    int          gap;   // idle cycles before this word; -1 = don't care
  } exp_t;

  exp_t        exp_q[$];
  logic [32:0] src2_q[$];
  logic [32:0] src3_q[$];
  int          chk_cnt   = 0;
  int          pass_cnt  = 0;
  int          xfer_cnt  = 0;
  int          flush_cnt = 0;
  int          mon_since = 0;
  exp_t        mon_e;
  logic        fire2;
  logic        fire3;
  int          base;
  int          f0;

  always #5 clk = ~clk;

  usb_in_ep_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .arb_enable      (arb_enable),
    .ep_mask         (ep_mask),
    .ep2_data        (ep2_data),
    .ep2_valid       (ep2_valid),
    .ep2_last        (ep2_last),
    .ep2_ready       (ep2_ready),
    .ep3_data        (ep3_data),
    .ep3_valid       (ep3_valid),
    .ep3_last        (ep3_last),
    .ep3_ready       (ep3_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_ep           (tx_ep),
    .tx_last         (tx_last),
    .tx_flush        (tx_flush),
    .grant_ep        (grant_ep),
    .msc_burst_count (msc_burst_count),
    .raw_burst_count (raw_burst_count),
    .arb_state       (arb_state)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic push_src(input int ep, input logic [31:0] d, input logic l);
    if (ep == 2) src2_q.push_back({l, d});
    else         src3_q.push_back({l, d});
  endtask

  task automatic push_exp(input int ep, input logic [31:0] d, input logic l, input int gap);
    exp_t e;
    e.data = d;
    e.ep   = 2'(ep);
    e.last = l;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_xfer(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (xfer_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(xfer_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src2_q.size() != 0 || src3_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    src2_q.delete();
    src3_q.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // EP2 source: presents the head of its queue, pops after an accepted word.
  initial begin
    ep2_valid = 1'b0; ep2_data = 32'd0; ep2_last = 1'b0;
    forever begin
      @(negedge clk);
      fire2 = ep2_valid & ep2_ready;
      @(posedge clk);
      #1;
      if (fire2 && src2_q.size() > 0) void'(src2_q.pop_front());
      if (src2_q.size() > 0) begin
        ep2_valid = 1'b1; ep2_last = src2_q[0][32]; ep2_data = src2_q[0][31:0];
      end else begin
        ep2_valid = 1'b0; ep2_last = 1'b0; ep2_data = 32'd0;
      end
    end
  end

  // EP3 source: same behaviour as the EP2 source.
  initial begin
    ep3_valid = 1'b0; ep3_data = 32'd0; ep3_last = 1'b0;
    forever begin
      @(negedge clk);
      fire3 = ep3_valid & ep3_ready;
      @(posedge clk);
      #1;
      if (fire3 && src3_q.size() > 0) void'(src3_q.pop_front());
      if (src3_q.size() > 0) begin
        ep3_valid = 1'b1; ep3_last = src3_q[0][32]; ep3_data = src3_q[0][31:0];
      end else begin
        ep3_valid = 1'b0; ep3_last = 1'b0; ep3_data = 32'd0;
      end
    end
  end

  // Monitor: compare every transferred word against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_flush) flush_cnt++;
      if (!rst && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_word: got data 0x%0h ep %0d, expected no transfer", tx_data, tx_ep);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_data", tx_data, mon_e.data);
          check("tx_ep", 32'(tx_ep), 32'(mon_e.ep));
          check("tx_last", 32'(tx_last), 32'(mon_e.last));
          if (mon_e.gap >= 0) check("burst_gap", 32'(mon_since), 32'(mon_e.gap));
        end
        xfer_cnt++;
        mon_since = 0;
      end else begin
        mon_since++;
      end
    end
  end

  // Watchdog against a hung run.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arb_enable = 1'b1; ep_mask = 2'b00; tx_ready = 1'b1;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_tx_ep", 32'(tx_ep), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_tx_flush", 32'(tx_flush), 32'd0);
    check("rst_grant", 32'(grant_ep), 32'd0);
    check("rst_ready", 32'({ep2_ready, ep3_ready}), 32'd0);
    check("rst_counts", {msc_burst_count, raw_burst_count}, 32'd0);
    check("rst_state", 32'(arb_state), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // EP2 alone, 600 words: bursts 256/256/88 with a reload bubble between.
    for (int n = 1; n <= 600; n++) begin
      push_src(2, 32'h2000_0000 + 32'(n), n == 600);
      push_exp(2, 32'h2000_0000 + 32'(n), (n % 256 == 0) || (n == 600),
               (n == 1) ? -1 : ((n == 257 || n == 513) ? 2 : 0));
    end
    wait_done(2000, "t1_drain");
    check("t1_msc_count", 32'(msc_burst_count), 32'd3);
    check("t1_raw_count", 32'(raw_burst_count), 32'd0);
    check("t1_state", 32'(arb_state), 32'd0);

    // Both endpoints busy: EP2, EP3, EP3, EP3, reload, EP2, EP3, EP3, EP3.
    do_reset();
    for (int n = 0; n < 8; n++)  push_src(2, 32'h2200_0000 + 32'(n), (n % 4) == 3);
    for (int n = 0; n < 24; n++) push_src(3, 32'h3200_0000 + 32'(n), (n % 4) == 3);
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < 4; w++)
        push_exp(2, 32'h2200_0000 + 32'(r * 4 + w), w == 3, (w == 0) ? ((r == 0) ? -1 : 2) : 0);
      for (int p = 0; p < 3; p++)
        for (int w = 0; w < 4; w++)
          push_exp(3, 32'h3200_0000 + 32'((r * 3 + p) * 4 + w), w == 3, (w == 0) ? 1 : 0);
    end
    wait_done(500, "t2_drain");
    check("t2_msc_count", 32'(msc_burst_count), 32'd2);
    check("t2_raw_count", 32'(raw_burst_count), 32'd6);

    // EP3 sends 10 words then goes idle: flush on the 16th idle cycle.
    do_reset();
    base = xfer_cnt;
    f0 = flush_cnt;
    for (int n = 0; n < 10; n++) begin
      push_src(3, 32'h3300_0000 + 32'(n), 1'b0);
      push_exp(3, 32'h3300_0000 + 32'(n), 1'b0, (n == 0) ? -1 : 0);
    end
    wait_xfer(base + 10, 100, "t3_words");
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("t3_flush_c%0d", k), 32'(tx_flush), 32'(k == 16));
      check($sformatf("t3_state_c%0d", k), 32'(arb_state), (k <= 16) ? 32'd2 : 32'd0);
    end
    check("t3_flush_count", 32'(flush_cnt - f0), 32'd1);
    check("t3_raw_count", 32'(raw_burst_count), 32'd1);
    wait_done(50, "t3_drain");

    // EP3 under 100 cycles of backpressure: no timeout, no flush, no progress.
    do_reset();
    base = xfer_cnt;
    f0 = flush_cnt;
    for (int n = 0; n < 5; n++) begin
      push_src(3, 32'h3400_0000 + 32'(n), n == 4);
      push_exp(3, 32'h3400_0000 + 32'(n), n == 4, -1);
    end
    wait_xfer(base + 2, 100, "t4_start");
    #1 tx_ready = 1'b0;
    repeat (100) @(negedge clk);
    check("t4_state_held", 32'(arb_state), 32'd2);
    check("t4_valid_held", 32'(tx_valid), 32'd1);
    check("t4_no_progress", 32'(xfer_cnt - base), 32'd2);
    check("t4_no_flush", 32'(flush_cnt - f0), 32'd0);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_done(100, "t4_drain");
    check("t4_raw_count", 32'(raw_burst_count), 32'd1);
    check("t4_flush_after", 32'(flush_cnt - f0), 32'd0);

    // Mask EP2, then swap the mask mid-burst: EP3 finishes, EP2 follows.
    do_reset();
    ep_mask = 2'b01;
    base = xfer_cnt;
    for (int n = 0; n < 4; n++) push_src(2, 32'h2500_0000 + 32'(n), n == 3);
    for (int n = 0; n < 8; n++) begin
      push_src(3, 32'h3500_0000 + 32'(n), n == 7);
      push_exp(3, 32'h3500_0000 + 32'(n), n == 7, (n == 0) ? -1 : 0);
    end
    for (int n = 0; n < 4; n++) push_exp(2, 32'h2500_0000 + 32'(n), n == 3, (n == 0) ? 1 : 0);
    wait_xfer(base + 3, 100, "t5_start");
    #1 ep_mask = 2'b10;
    wait_done(200, "t5_drain");
    check("t5_msc_count", 32'(msc_burst_count), 32'd1);
    check("t5_raw_count", 32'(raw_burst_count), 32'd1);
    check("t5_grant_idle", 32'(grant_ep), 32'd0);
    ep_mask = 2'b00;

    // Reset at word 40 of an EP2 burst, then both valid: EP2 first.
    do_reset();
    base = xfer_cnt;
    for (int n = 0; n < 100; n++) begin
      push_src(2, 32'h2600_0000 + 32'(n), n == 99);
      push_exp(2, 32'h2600_0000 + 32'(n), n == 99, (n == 0) ? -1 : 0);
    end
    wait_xfer(base + 40, 200, "t6_word40");
    check("t6_granted_before", 32'(grant_ep), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("t6_rst_ep2_ready", 32'(ep2_ready), 32'd0);
    check("t6_rst_grant", 32'(grant_ep), 32'd0);
    check("t6_rst_counts", {msc_burst_count, raw_burst_count}, 32'd0);
    src2_q.delete();
    src3_q.delete();
    exp_q.delete();
    for (int n = 0; n < 4; n++) begin
      push_src(2, 32'h2700_0000 + 32'(n), n == 3);
      push_src(3, 32'h3700_0000 + 32'(n), n == 3);
    end
    for (int n = 0; n < 4; n++) push_exp(2, 32'h2700_0000 + 32'(n), n == 3, (n == 0) ? -1 : 0);
    for (int n = 0; n < 4; n++) push_exp(3, 32'h3700_0000 + 32'(n), n == 3, (n == 0) ? 1 : 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    wait_done(200, "t6_drain");
    check("t6_msc_count", 32'(msc_burst_count), 32'd1);
    check("t6_raw_count", 32'(raw_burst_count), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
